wb_arbiter: RTL and testbench
=============================

WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter LSU_FIFO_DEPTH, default 4, sets the LSU writeback queue depth; legal values are powers of two from 2 to 16.
REQ-002 Port clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  reset; synchronous and active-high, sampled on the rising edge of clk.
REQ-004 Port alu_wb_vld  input  1  ALU result valid this cycle; single-cycle pulse; no backpressure.
REQ-005 Port alu_wb_addr  input  5  ALU destination register index.
REQ-006 Port alu_wb_data  input  64  ALU result.
REQ-007 Port lsu_wb_vld  input  1  load result offered.
REQ-008 Port lsu_wb_addr  input  5  load destination register index.
REQ-009 Port lsu_wb_data  input  64  load data, already extended.
REQ-010 Port lsu_wb_rdy  output  1  queue can accept a load result this cycle.
REQ-011 Port rf_we  output  1  register file write enable, registered.
REQ-012 Port rf_waddr  output  5  register file write index, registered.
REQ-013 Port rf_wdata  output  64  register file write data, registered.
REQ-014 Port wb_done_vld  output  1  a destination has retired this cycle, for scoreboard clear; registered.
REQ-015 Port wb_done_addr  output  5  retired destination index.
REQ-016 Port lsu_fifo_cnt  output  $clog2(LSU_FIFO_DEPTH)+1  current queue occupancy.

Function
REQ-017 ALU results have absolute priority: alu_wb_vld in cycle c -> wb_done_vld=1, wb_done_addr=alu_wb_addr in cycle c+1, with rf_waddr=alu_wb_addr and rf_wdata=alu_wb_data.
REQ-018 Load results pass through a circular FIFO of LSU_FIFO_DEPTH entries; the FIFO enqueues when lsu_wb_vld & lsu_wb_rdy.
REQ-019 lsu_wb_rdy = (lsu_fifo_cnt < LSU_FIFO_DEPTH), derived combinationally from registered count only; when full, rdy is 0 even if a dequeue occurs the same cycle.
REQ-020 The FIFO head dequeues in any cycle where it is non-empty and alu_wb_vld=0; the dequeued entry drives the rf_* and wb_done_* outputs in the next cycle.
REQ-021 An entry enqueued in cycle c is dequeued no earlier than cycle c+1, so minimum load latency is 2 cycles (rf_we in c+2); there is no empty-queue bypass.
REQ-022 Simultaneous enqueue and dequeue leave lsu_fifo_cnt unchanged; read and write pointers wrap modulo LSU_FIFO_DEPTH.
REQ-023 Loads retire in acceptance order; an ALU pulse only delays the head and never reorders entries.
REQ-024 A selected write with index 0 gives rf_we=0, but wb_done_vld=1 and wb_done_addr=0 are still asserted.
REQ-025 When nothing is selected in a cycle, the next cycle has rf_we=0 and wb_done_vld=0, and rf_waddr/rf_wdata hold their previous values.
REQ-026 Back-to-back ALU pulses are each written in consecutive cycles; a continuously pulsing ALU stalls the FIFO indefinitely, and the upstream issue logic bounds this.
REQ-027 lsu_wb_addr/lsu_wb_data are ignored when lsu_wb_vld=0; alu_wb_addr/alu_wb_data are ignored when alu_wb_vld=0.

Reset
REQ-028 While rst=1 at a clock edge: rf_we=0, wb_done_vld=0, rf_waddr=0, rf_wdata=0, wb_done_addr=0, pointers=0, and lsu_fifo_cnt=0 after that edge.
REQ-029 Reset asserted mid-operation discards all queued loads without writing them; lsu_wb_rdy=1 in the first cycle after rst deasserts.
REQ-030 Inputs sampled in a cycle where rst=1 are discarded and are neither enqueued nor written.

Verification
REQ-031 ALU only: alu_wb_vld=1, addr=5, data=0x1234 in cycle 10 -> cycle 11: rf_we=1, rf_waddr=5, rf_wdata=0x1234, wb_done_vld=1; cycle 12: rf_we=0.
REQ-032 Collision: ALU (addr 3, 0xA) and LSU (addr 4, 0xB) both valid in cycle 10 -> cycle 11: write r3=0xA; cycle 12: write r4=0xB; lsu_fifo_cnt goes 1 then 0.
REQ-033 Fill and backpressure: alu_wb_vld held 1 for 6 cycles while the LSU offers loads r1..r6 -> rdy drops after 4 accepts, and lsu_fifo_cnt=4. Once the ALU stops, r1..r4 are written in order in 4 consecutive cycles, and r5 is accepted in the cycle after cnt falls below 4.
REQ-034 x0 write: LSU load to addr 0, data 0xFF -> 2 cycles later rf_we=0, wb_done_vld=1, wb_done_addr=0.
REQ-035 Reset mid-stream: 3 loads queued, rst=1 for 1 cycle -> no rf_we for those loads, lsu_fifo_cnt=0, and lsu_wb_rdy=1 the cycle after release.
REQ-036 Wrap-around: 10 loads enqueued and dequeued continuously at 1 per cycle -> all 10 are written in order with correct data, and cnt never exceeds 1.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: ALU result port, LSU load port with ready, and the
// register-file / scoreboard writeback outputs.
interface wb_arbiter_if #(
  parameter int LSU_FIFO_DEPTH = 4
);
  localparam int CW = $clog2(LSU_FIFO_DEPTH) + 1;

  logic          alu_wb_vld;
  logic [4:0]    alu_wb_addr;
  logic [63:0]   alu_wb_data;
  logic          lsu_wb_vld;
  logic [4:0]    lsu_wb_addr;
  logic [63:0]   lsu_wb_data;
  logic          lsu_wb_rdy;
  logic          rf_we;
  logic [4:0]    rf_waddr;
  logic [63:0]   rf_wdata;
  logic          wb_done_vld;
  logic [4:0]    wb_done_addr;
  logic [CW-1:0] lsu_fifo_cnt;

  modport master (
    output alu_wb_vld, alu_wb_addr, alu_wb_data,
    output lsu_wb_vld, lsu_wb_addr, lsu_wb_data,
    input  lsu_wb_rdy, rf_we, rf_waddr, rf_wdata,
    input  wb_done_vld, wb_done_addr, lsu_fifo_cnt
  );

  modport slave (
    input  alu_wb_vld, alu_wb_addr, alu_wb_data,
    input  lsu_wb_vld, lsu_wb_addr, lsu_wb_data,
    output lsu_wb_rdy, rf_we, rf_waddr, rf_wdata,
    output wb_done_vld, wb_done_addr, lsu_fifo_cnt
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results win outright, loads wait in a circular FIFO
// and drain whenever the ALU is idle. All writeback outputs are registered.
module wb_arbiter #(
  parameter int LSU_FIFO_DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  wb_arbiter_if.slave  bus
);
  localparam int PW = $clog2(LSU_FIFO_DEPTH);
  localparam int CW = PW + 1;

  logic [4:0]    r_addr [LSU_FIFO_DEPTH];
  logic [63:0]   r_data [LSU_FIFO_DEPTH];
  logic [PW-1:0] r_wptr, r_rptr;
  logic [CW-1:0] r_cnt;

  logic          r_we, r_done_vld;
  logic [4:0]    r_waddr, r_done_addr;
  logic [63:0]   r_wdata;

  logic          w_rdy, w_enq, w_deq, w_sel;
  logic [4:0]    w_sel_addr;
  logic [63:0]   w_sel_data;

  // Ready looks only at the registered count, so a full queue refuses a load
  // even in a cycle where it is also draining.
  assign w_rdy = (r_cnt < CW'(LSU_FIFO_DEPTH));
  assign w_enq = bus.lsu_wb_vld & w_rdy;
  assign w_deq = (r_cnt != '0) & ~bus.alu_wb_vld;

  always_comb begin
    w_sel      = bus.alu_wb_vld | w_deq;
    w_sel_addr = r_addr[r_rptr];
    w_sel_data = r_data[r_rptr];
    if (bus.alu_wb_vld) begin
      w_sel_addr = bus.alu_wb_addr;
      w_sel_data = bus.alu_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && w_enq) begin
      r_addr[r_wptr] <= bus.lsu_wb_addr;
      r_data[r_wptr] <= bus.lsu_wb_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_enq) r_wptr <= r_wptr + PW'(1);
      if (w_deq) r_rptr <= r_rptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - CW'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Writes to x0 still retire so the scoreboard clears, but never reach the RF.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_we        <= 1'b0;
      r_done_vld  <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_done_addr <= '0;
    end else begin
      r_we       <= w_sel && (w_sel_addr != 5'd0);
      r_done_vld <= w_sel;
      if (w_sel) begin
        r_waddr     <= w_sel_addr;
        r_wdata     <= w_sel_data;
        r_done_addr <= w_sel_addr;
      end
    end
  end

  assign bus.lsu_wb_rdy   = w_rdy;
  assign bus.lsu_fifo_cnt = r_cnt;
  assign bus.rf_we        = r_we;
  assign bus.rf_waddr     = r_waddr;
  assign bus.rf_wdata     = r_wdata;
  assign bus.wb_done_vld  = r_done_vld;
  assign bus.wb_done_addr = r_done_addr;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: ALU priority, load queueing, backpressure,
// x0 writes, reset flush and pointer wrap, with hand-computed expectations.
module tb_wb_arbiter;
  localparam int D = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.LSU_FIFO_DEPTH(D)) bus ();

  wb_arbiter #(.LSU_FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.alu_wb_vld  = 1'b0;
    bus.alu_wb_addr = 5'd0;
    bus.alu_wb_data = 64'd0;
    bus.lsu_wb_vld  = 1'b0;
    bus.lsu_wb_addr = 5'd0;
    bus.lsu_wb_data = 64'd0;
  endtask

  task automatic alu(input logic [4:0] a, input logic [63:0] d);
    bus.alu_wb_vld  = 1'b1;
    bus.alu_wb_addr = a;
    bus.alu_wb_data = d;
  endtask

  task automatic lsu(input logic [4:0] a, input logic [63:0] d);
    bus.lsu_wb_vld  = 1'b1;
    bus.lsu_wb_addr = a;
    bus.lsu_wb_data = d;
  endtask

  task automatic chk_wr(input string tag, input logic we, input logic [4:0] a, input logic [63:0] d);
    chk({tag, ".we"},    64'(bus.rf_we), 64'(we));
    chk({tag, ".waddr"}, 64'(bus.rf_waddr), 64'(a));
    chk({tag, ".wdata"}, bus.rf_wdata, d);
    chk({tag, ".done"},  64'(bus.wb_done_vld), 64'd1);
    chk({tag, ".daddr"}, 64'(bus.wb_done_addr), 64'(a));
  endtask

  initial begin
    #100000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    int k;
    idle();
    // reset with garbage on the inputs: nothing may be captured
    alu(5'd9, 64'hDEAD);
    lsu(5'd8, 64'hBEEF);
    tick();
    tick();
    chk("rst.we",    64'(bus.rf_we), 64'd0);
    chk("rst.done",  64'(bus.wb_done_vld), 64'd0);
    chk("rst.waddr", 64'(bus.rf_waddr), 64'd0);
    chk("rst.wdata", bus.rf_wdata, 64'd0);
    chk("rst.daddr", 64'(bus.wb_done_addr), 64'd0);
    chk("rst.cnt",   64'(bus.lsu_fifo_cnt), 64'd0);
    idle();
    rst = 1'b0;
    chk("rst.rdy",   64'(bus.lsu_wb_rdy), 64'd1);
    tick();
    chk("rst.post_we", 64'(bus.rf_we), 64'd0);

    // ALU only
    alu(5'd5, 64'h1234);
    tick();
    idle();
    chk_wr("alu", 1'b1, 5'd5, 64'h1234);
    tick();
    chk("alu.we_off",   64'(bus.rf_we), 64'd0);
    chk("alu.done_off", 64'(bus.wb_done_vld), 64'd0);
    chk("alu.hold_a",   64'(bus.rf_waddr), 64'd5);
    chk("alu.hold_d",   bus.rf_wdata, 64'h1234);

    // collision: ALU first, load next cycle
    alu(5'd3, 64'hA);
    lsu(5'd4, 64'hB);
    tick();
    idle();
    chk_wr("col.alu", 1'b1, 5'd3, 64'hA);
    chk("col.cnt1", 64'(bus.lsu_fifo_cnt), 64'd1);
    tick();
    chk_wr("col.lsu", 1'b1, 5'd4, 64'hB);
    chk("col.cnt0", 64'(bus.lsu_fifo_cnt), 64'd0);
    tick();
    chk("col.idle", 64'(bus.rf_we), 64'd0);

    // fill under a 6-cycle ALU burst; loads r1.. offered throughout
    k = 1;
    for (int i = 0; i < 6; i++) begin
      alu(5'(20 + i), 64'(32'h500 + i));
      lsu(5'(k), 64'(32'h100 + k));
      chk($sformatf("fill.rdy%0d", i), 64'(bus.lsu_wb_rdy), 64'(i < 4));
      tick();
      if (i < 4) k++;
      chk_wr($sformatf("fill.alu%0d", i), 1'b1, 5'(20 + i), 64'(32'h500 + i));
    end
    chk("fill.cnt", 64'(bus.lsu_fifo_cnt), 64'd4);
    bus.alu_wb_vld = 1'b0;
    // r5 still offered; queue full so refused this cycle, r1 drains
    chk("fill.rdy_full", 64'(bus.lsu_wb_rdy), 64'd0);
    tick();
    chk_wr("drain.r1", 1'b1, 5'd1, 64'h101);
    chk("drain.cnt3", 64'(bus.lsu_fifo_cnt), 64'd3);
    chk("drain.rdy5", 64'(bus.lsu_wb_rdy), 64'd1);
    tick();
    lsu(5'd6, 64'h106);
    chk_wr("drain.r2", 1'b1, 5'd2, 64'h102);
    chk("drain.cnt3b", 64'(bus.lsu_fifo_cnt), 64'd3);
    tick();
    idle();
    chk_wr("drain.r3", 1'b1, 5'd3, 64'h103);
    for (int r = 4; r <= 6; r++) begin
      tick();
      chk_wr($sformatf("drain.r%0d", r), 1'b1, 5'(r), 64'(32'h100 + r));
    end
    chk("drain.cnt0", 64'(bus.lsu_fifo_cnt), 64'd0);
    tick();
    chk("drain.idle", 64'(bus.rf_we), 64'd0);

    // x0 load: retires without an RF write, two cycles after the offer
    lsu(5'd0, 64'hFF);
    tick();
    idle();
    chk("x0.c1_done", 64'(bus.wb_done_vld), 64'd0);
    tick();
    chk("x0.we",    64'(bus.rf_we), 64'd0);
    chk("x0.done",  64'(bus.wb_done_vld), 64'd1);
    chk("x0.daddr", 64'(bus.wb_done_addr), 64'd0);

    // reset mid-stream: three loads parked behind ALU traffic
    for (int i = 0; i < 3; i++) begin
      alu(5'd7, 64'(i));
      lsu(5'(10 + i), 64'(32'h300 + i));
      tick();
    end
    chk("mrst.cnt3", 64'(bus.lsu_fifo_cnt), 64'd3);
    rst = 1'b1;
    alu(5'd14, 64'h77);
    lsu(5'd13, 64'h313);
    tick();
    rst = 1'b0;
    idle();
    chk("mrst.cnt0", 64'(bus.lsu_fifo_cnt), 64'd0);
    chk("mrst.we",   64'(bus.rf_we), 64'd0);
    chk("mrst.rdy",  64'(bus.lsu_wb_rdy), 64'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mrst.nowr%0d", i), 64'(bus.rf_we), 64'd0);
      chk($sformatf("mrst.nodone%0d", i), 64'(bus.wb_done_vld), 64'd0);
    end

    // wrap-around: one load per cycle, streaming through the pointers
    for (int i = 0; i < 12; i++) begin
      if (i < 10) lsu(5'(i + 1), 64'(32'h200 + i));
      else idle();
      if (i < 10) chk($sformatf("wrap.rdy%0d", i), 64'(bus.lsu_wb_rdy), 64'd1);
      tick();
      chk($sformatf("wrap.cnt%0d", i), 64'(bus.lsu_fifo_cnt), 64'(i < 10));
      if (i >= 1 && i <= 10)
        chk_wr($sformatf("wrap.w%0d", i), 1'b1, 5'(i), 64'(32'h200 + i - 1));
    end
    chk("wrap.idle", 64'(bus.rf_we), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
